// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path: accumulator width, drain FSM encoding
// and the drain-index to (row, col) mapping.
package systolic_pkg;

    function automatic int calc_o_bits(input int i_bits, input int dimension);
        return (i_bits * 2) + $clog2(dimension);
    endfunction

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } drain_state_t;

    // Column-major makes the row index vary fastest.
    function automatic int elem_row(input int idx, input int dimension, input bit col_major);
        return col_major ? (idx % dimension) : (idx / dimension);
    endfunction

    function automatic int elem_col(input int idx, input int dimension, input bit col_major);
        return col_major ? (idx / dimension) : (idx % dimension);
    endfunction

endpackage

// File: rtl/systolic_result_drain.sv
// Snapshots each PE accumulator on its finish pulse, then streams the whole frame out.
// Latency: o_valid one cycle after the last missing finish bit; one word per cycle while i_ready.
// Backpressure: i_ready low freezes the current word; SYSTOLIC_DRAIN_COLMAJOR_EN selects column-major order.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int DIMENSION = 4,
    parameter int I_BITS    = 8,
    parameter int O_BITS    = calc_o_bits(I_BITS, DIMENSION)
) (
    input  logic                                   i_clock,
    input  logic                                   i_reset,
    input  logic [DIMENSION*DIMENSION*O_BITS-1:0]  i_c,
    input  logic [DIMENSION*DIMENSION-1:0]         i_finish,
    output logic [O_BITS-1:0]                      o_data,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [$clog2(DIMENSION)-1:0]           o_row,
    output logic [$clog2(DIMENSION)-1:0]           o_col,
    output logic                                   o_last,
    output logic                                   o_busy,
    output logic                                   o_overrun
);

    localparam int N     = DIMENSION * DIMENSION;
    localparam int IDX_W = $clog2(N);
    localparam int RC_W  = $clog2(DIMENSION);

`ifdef SYSTOLIC_DRAIN_COLMAJOR_EN
    localparam bit COL_MAJOR = 1'b1;
`else
    localparam bit COL_MAJOR = 1'b0;
`endif

    drain_state_t        state_q, state_d;
    logic [N-1:0]        got_q, got_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                overrun_q, overrun_d;
    logic                capture_en;
    logic                handshake;
    logic                final_hs;
    logic [O_BITS-1:0]   result_buf [N];

    logic [RC_W-1:0]     cur_row;
    logic [RC_W-1:0]     cur_col;
    logic [IDX_W-1:0]    cur_k;

    assign cur_row = RC_W'(elem_row(int'(idx_q), DIMENSION, COL_MAJOR));
    assign cur_col = RC_W'(elem_col(int'(idx_q), DIMENSION, COL_MAJOR));
    assign cur_k   = IDX_W'(int'(cur_row) * DIMENSION + int'(cur_col));

    assign handshake = (state_q == DRAIN) && i_ready;
    assign final_hs  = handshake && (idx_q == IDX_W'(N - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        got_d      = got_q;
        idx_d      = idx_q;
        overrun_d  = overrun_q;
        capture_en = 1'b0;
        case (state_q)
            COLLECT: begin
                capture_en = 1'b1;
                got_d      = got_q | i_finish;
                idx_d      = '0;
                if (|(got_q & i_finish)) begin
                    overrun_d = 1'b1;
                end
                if (&(got_q | i_finish)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (final_hs) begin
                    // Pulses on the closing beat seed the next frame's mask.
                    capture_en = 1'b1;
                    got_d      = i_finish;
                    idx_d      = '0;
                    state_d    = COLLECT;
                end else begin
                    if (handshake) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (|i_finish) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            got_q     <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            got_q     <= got_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < N; k++) begin
                result_buf[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (capture_en && i_finish[k]) begin
                    result_buf[k] <= i_c[k*O_BITS +: O_BITS];
                end
            end
        end
    end

    // o_data reads the registered buffer, so the closing beat still shows the old word.
    assign o_data    = result_buf[cur_k];
    assign o_row     = cur_row;
    assign o_col     = cur_col;
    assign o_valid   = (state_q == DRAIN);
    assign o_busy    = (state_q == DRAIN);
    assign o_last    = (state_q == DRAIN) && (idx_q == IDX_W'(N - 1));
    assign o_overrun = overrun_q;

endmodule
